cardinal_dmem_arbiter: RTL and testbench
========================================

CARDINAL_DMEM_ARBITER -- requirements
Module: cardinal_dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-low, and the ports are named Clock and Reset as elsewhere in the codebase.
REQ-002 Parameter STARVE_LIMIT, default 8: number of pending cycles at or above which ext_starved asserts (legal range 1..255).
REQ-003 Port Clock  in  1  rising-edge clock.
REQ-004 Port Reset  in  1  asynchronous, active-low reset.
REQ-005 Port cpu_Addr  in  [0:7]  processor data-memory address.
REQ-006 Port cpu_Data_Out  in  [0:63]  processor store data.
REQ-007 Port cpu_En  in  1  processor access this cycle.
REQ-008 Port cpu_WrEn  in  1  processor write qualifier, valid only with cpu_En.
REQ-009 Port cpu_Data_In  out  [0:63]  load data to the processor; this is a combinational pass-through of mem_Data_In.
REQ-010 Port ext_valid  in  1  external requester offers a request.
REQ-011 Port ext_ready  out  1  request buffer empty, so a request can be accepted.
REQ-012 Port ext_wr  in  1  1 = write, 0 = read.
REQ-013 Port ext_addr  in  [0:7]  external address.
REQ-014 Port ext_wdata  in  [0:63]  external write data.
REQ-015 Port ext_rvalid  out  1  ext_rdata valid, one-cycle pulse.
REQ-016 Port ext_rdata  out  [0:63]  registered external read data.
REQ-017 Port ext_starved  out  1  pending external request has waited at least STARVE_LIMIT cycles.
REQ-018 Port mem_Addr, mem_Data_Out, mem_En, mem_WrEn  out  [0:7], [0:63], 1, 1  single-port memory controls.
REQ-019 Port mem_Data_In  in  [0:63]  memory read data, sampled at the edge that ends the access cycle.

Function
REQ-020 The processor SHALL have absolute priority; it is never stalled or delayed by the block.
REQ-021 The memory port SHALL be driven from the cpu_* inputs whenever cpu_En=1; this path is combinational with zero added latency.
REQ-022 The one-entry request buffer SHALL have two states, EMPTY and FULL.
REQ-023 ext_ready SHALL equal 1 exactly when the buffer is EMPTY.
REQ-024 A request SHALL be accepted at the edge where ext_valid and ext_ready are both 1; at that edge the buffer captures wr, addr and wdata and moves EMPTY->FULL.
REQ-025 While the buffer is FULL, the buffered request SHALL be issued in any cycle where cpu_En=0, by driving mem_* from the buffer with mem_En=1 and mem_WrEn=buffered wr.
REQ-026 At the end of an issue cycle the buffer SHALL move FULL->EMPTY.
REQ-027 The buffer SHALL NOT accept a new request in the same cycle it issues; ext_ready rises the cycle after issue.
REQ-028 Back-to-back external throughput SHALL therefore be at most one request per 2 cycles.
REQ-029 Issue timing (cycle counts from acceptance edge): issue cycle >= acceptance edge +1; no same-edge bypass of an incoming request to memory.
REQ-030 For an issued read, ext_rdata SHALL register mem_Data_In at the end of the issue cycle, and ext_rvalid SHALL be 1 for exactly the following cycle.
REQ-031 An issued write SHALL produce no ext_rvalid.
REQ-032 ext_rdata SHALL hold its value until the next external read completes.
REQ-033 When no access is active (cpu_En=0 and buffer EMPTY), mem_En and mem_WrEn SHALL be 0 and mem_Addr and mem_Data_Out SHALL be 0.
REQ-034 The wait counter SHALL be 8 bits: it clears on acceptance and increments each cycle the buffer is FULL and not issued, saturating at 255.
REQ-035 ext_starved SHALL equal FULL and (wait counter >= STARVE_LIMIT); it clears on issue.
REQ-036 The block SHALL perform no address-conflict ordering: a processor write and a pending external read of the same address resolve in issue order.
REQ-037 Changes on ext_* inputs while the buffer is FULL SHALL be ignored.

Reset
REQ-038 Reset=0 SHALL asynchronously force: buffer EMPTY, ext_ready=1, ext_rvalid=0, ext_rdata=0, wait counter=0, ext_starved=0.
REQ-039 On deassertion of Reset, the block SHALL resume with the first rising edge at which Reset=1.
REQ-040 If reset occurs mid-operation, it SHALL discard the buffered request and any pending rvalid; no memory access is issued for them.
REQ-041 During reset the mem_* outputs SHALL still follow the cpu_* inputs combinationally.

Verification
REQ-042 Scenario: cpu_En=0; ext read addr 0x10 accepted at edge 0 -> cycle 1 mem_En=1, mem_Addr=0x10, mem_WrEn=0; cycle 2 ext_rvalid=1 with ext_rdata=mem data; ext_ready=1 in cycle 2.
REQ-043 Scenario: ext write addr 0x05, data 0xAAAA_5555_0000_FFFF with cpu_En=1 for 3 cycles -> no external issue in those cycles; issue in the 4th cycle with mem_WrEn=1; ext_rvalid stays 0.
REQ-044 Scenario: STARVE_LIMIT=8 and cpu_En=1 for 12 cycles while the buffer is FULL -> ext_starved rises after 8 waiting cycles; it drops in the cycle after issue.
REQ-045 Scenario: ext_valid held at 1 continuously with cpu_En=0 -> accepts occur every 2 cycles; ext_ready toggles 1,0,1,0.
REQ-046 Scenario: Reset pulsed low while the buffer is FULL and a read is pending -> ext_ready=1 immediately, and no mem_En from the ext side or ext_rvalid appears afterward.
REQ-047 Scenario: cpu_En=1 with cpu_Addr=0x22 and the buffer EMPTY -> mem_Addr=0x22 and cpu_Data_In equals mem_Data_In in the same cycle.

Source files
------------

// File: rtl/cardinal_dmem_arbiter_if.sv
// cardinal_dmem_arbiter_if: processor, external-requester and memory buses of the data-memory arbiter
interface cardinal_dmem_arbiter_if;
  logic [0:7]  cpu_Addr;
  logic [0:63] cpu_Data_Out;
  logic        cpu_En;
  logic        cpu_WrEn;
  logic [0:63] cpu_Data_In;
  logic        ext_valid;
  logic        ext_ready;
  logic        ext_wr;
  logic [0:7]  ext_addr;
  logic [0:63] ext_wdata;
  logic        ext_rvalid;
  logic [0:63] ext_rdata;
  logic        ext_starved;
  logic [0:7]  mem_Addr;
  logic [0:63] mem_Data_Out;
  logic        mem_En;
  logic        mem_WrEn;
  logic [0:63] mem_Data_In;
  modport slave (
    input  cpu_Addr, cpu_Data_Out, cpu_En, cpu_WrEn, ext_valid, ext_wr, ext_addr, ext_wdata, mem_Data_In,
    output cpu_Data_In, ext_ready, ext_rvalid, ext_rdata, ext_starved, mem_Addr, mem_Data_Out, mem_En, mem_WrEn
  );
  modport master (
    output cpu_Addr, cpu_Data_Out, cpu_En, cpu_WrEn, ext_valid, ext_wr, ext_addr, ext_wdata, mem_Data_In,
    input  cpu_Data_In, ext_ready, ext_rvalid, ext_rdata, ext_starved, mem_Addr, mem_Data_Out, mem_En, mem_WrEn
  );
endinterface

// File: rtl/cardinal_dmem_arbiter.sv
// cardinal_dmem_arbiter: shares a single-port data memory; the processor always wins, one buffered external request fills idle cycles
module cardinal_dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic Clock,
  input logic Reset,
  cardinal_dmem_arbiter_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [0:7]  addr_q, addr_d;
  logic [0:63] wdata_q, wdata_d;
  logic        rvalid_q, rvalid_d;
  logic [0:63] rdata_q, rdata_d;
  logic [7:0]  wait_q, wait_d;
  logic        accept, issue;
  assign bus.ext_ready   = state_q == EMPTY;
  assign accept          = bus.ext_valid && bus.ext_ready;
  assign issue           = state_q == FULL && !bus.cpu_En;
  assign bus.ext_rvalid  = rvalid_q;
  assign bus.ext_rdata   = rdata_q;
  assign bus.ext_starved = state_q == FULL && wait_q >= LIMIT;
  assign bus.cpu_Data_In = bus.mem_Data_In;
  // processor path is purely combinational; the buffer only drives memory when the processor is idle
  assign bus.mem_En       = bus.cpu_En || issue;
  assign bus.mem_WrEn     = bus.cpu_En ? bus.cpu_WrEn : issue && wr_q;
  assign bus.mem_Addr     = bus.cpu_En ? bus.cpu_Addr : issue ? addr_q : '0;
  assign bus.mem_Data_Out = bus.cpu_En ? bus.cpu_Data_Out : issue ? wdata_q : '0;
  always_comb begin
    state_d  = accept ? FULL : issue ? EMPTY : state_q;
    wr_d     = accept ? bus.ext_wr : wr_q;
    addr_d   = accept ? bus.ext_addr : addr_q;
    wdata_d  = accept ? bus.ext_wdata : wdata_q;
    rvalid_d = issue && !wr_q;
    rdata_d  = rvalid_d ? bus.mem_Data_In : rdata_q;
    wait_d   = accept ? 8'd0 : (state_q == FULL && !issue && wait_q != 8'hFF) ? wait_q + 8'd1 : wait_q;
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= EMPTY;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
    end
  end
endmodule

// File: tb/tb_cardinal_dmem_arbiter.sv
// tb_cardinal_dmem_arbiter: randomized traffic against a transaction-level model of the arbiter
module tb_cardinal_dmem_arbiter;
  localparam int LIMIT = 8;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int checks = 0;
  int errors = 0;
  cardinal_dmem_arbiter_if bus();
  cardinal_dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.Clock(Clock), .Reset(Reset), .bus(bus.slave));
  always #5 Clock = ~Clock;
  bit          m_pend, m_wr, m_rv;
  logic [7:0]  m_addr;
  logic [63:0] m_wdata, m_rd;
  int          m_age;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_pend = 0; m_wr = 0; m_rv = 0; m_addr = '0; m_wdata = '0; m_rd = '0; m_age = 0;
  endtask
  task automatic drive(input int pct_cpu, input int pct_valid);
    bus.cpu_En       = ($urandom % 100) < pct_cpu;
    bus.cpu_WrEn     = $urandom % 2;
    bus.cpu_Addr     = 8'($urandom);
    bus.cpu_Data_Out = {$urandom, $urandom};
    bus.ext_valid    = ($urandom % 100) < pct_valid;
    bus.ext_wr       = $urandom % 2;
    bus.ext_addr     = 8'($urandom);
    bus.ext_wdata    = {$urandom, $urandom};
    bus.mem_Data_In  = {$urandom, $urandom};
  endtask
  task automatic check_outputs();
    logic [63:0] e_addr, e_data;
    e_addr = bus.cpu_En ? 64'(bus.cpu_Addr) : m_pend ? 64'(m_addr) : 64'd0;
    e_data = bus.cpu_En ? 64'(bus.cpu_Data_Out) : m_pend ? m_wdata : 64'd0;
    chk("ext_ready", 64'(bus.ext_ready), 64'(!m_pend));
    chk("ext_rvalid", 64'(bus.ext_rvalid), 64'(m_rv));
    chk("ext_rdata", bus.ext_rdata, m_rd);
    chk("ext_starved", 64'(bus.ext_starved), 64'(m_pend && m_age >= LIMIT));
    chk("mem_En", 64'(bus.mem_En), 64'(bus.cpu_En || m_pend));
    chk("mem_WrEn", 64'(bus.mem_WrEn), 64'(bus.cpu_En ? bus.cpu_WrEn : (m_pend && m_wr)));
    chk("mem_Addr", 64'(bus.mem_Addr), e_addr);
    chk("mem_Data_Out", bus.mem_Data_Out, e_data);
    chk("cpu_Data_In", bus.cpu_Data_In, bus.mem_Data_In);
  endtask
  task automatic model_step();
    bit was, iss;
    was = m_pend;
    iss = m_pend && !bus.cpu_En;
    m_rv = iss && !m_wr;
    if (m_rv) m_rd = bus.mem_Data_In;
    if (iss) m_pend = 0;
    else if (m_pend) m_age = m_age < 255 ? m_age + 1 : 255;
    if (!was && bus.ext_valid) begin
      m_pend = 1; m_wr = bus.ext_wr; m_addr = bus.ext_addr; m_wdata = bus.ext_wdata; m_age = 0;
    end
  endtask
  initial begin
    int seg_cpu[6]   = '{0, 10, 50, 95, 100, 30};
    int seg_valid[6] = '{100, 60, 50, 80, 100, 70};
    int seg_len[6]   = '{40, 200, 200, 200, 300, 200};
    model_reset();
    drive(0, 0);
    #2;
    chk("rst_ready", 64'(bus.ext_ready), 64'd1);
    chk("rst_rvalid", 64'(bus.ext_rvalid), 64'd0);
    chk("rst_rdata", bus.ext_rdata, 64'd0);
    chk("rst_starved", 64'(bus.ext_starved), 64'd0);
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < seg_len[s]; c++) begin
        drive(seg_cpu[s], seg_valid[s]);
        @(negedge Clock);
        check_outputs();
        if (s > 0 && s < 4 && ($urandom % 60) == 0) begin
          Reset = 1'b0;
          #1;
          chk("rst_ready", 64'(bus.ext_ready), 64'd1);
          chk("rst_rvalid", 64'(bus.ext_rvalid), 64'd0);
          chk("rst_rdata", bus.ext_rdata, 64'd0);
          chk("rst_starved", 64'(bus.ext_starved), 64'd0);
          chk("rst_mem_En", 64'(bus.mem_En), 64'(bus.cpu_En));
          chk("rst_mem_Addr", 64'(bus.mem_Addr), bus.cpu_En ? 64'(bus.cpu_Addr) : 64'd0);
          model_reset();
          @(posedge Clock);
          #1 Reset = 1'b1;
        end else begin
          model_step();
          @(posedge Clock);
          #1;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
